sobel_gradient: RTL and testbench

SOBEL_GRADIENT -- requirements
Module: sobel_gradient

---
 rtl/sobel_gradient_if.sv | 40 ++++
 rtl/sobel_gradient.sv | 146 ++++++++++++++
 tb/tb_sobel_gradient.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sobel_gradient_if.sv
// ============================================================================
//  Module      : sobel_gradient_if
//  Description : Bundle of pixel-load, control and result signals of the
//                Sobel gradient block.
//                master : producer side (drives pixels / commands)
//                slave  : the gradient block itself
//  Signals     : i_gray_data[7:0]      pixel to store
//                i_b1_save             store pulse
//                i_b1_clear            empty-window pulse
//                i_gradient_start      start-computation pulse
//                o_b1_full             window holds 9 pixels
//                o_gradient_data[7:0]  registered result
//                o_gradient_data_ready one-cycle result-valid pulse
//                o_busy                computation in progress
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface sobel_gradient_if;
    logic [7:0] i_gray_data;
    logic       i_b1_save;
    logic       i_b1_clear;
    logic       i_gradient_start;
    logic       o_b1_full;
    logic [7:0] o_gradient_data;
    logic       o_gradient_data_ready;
    logic       o_busy;

    modport master (
        output i_gray_data, i_b1_save, i_b1_clear, i_gradient_start,
        input  o_b1_full, o_gradient_data, o_gradient_data_ready, o_busy
    );

    modport slave (
        input  i_gray_data, i_b1_save, i_b1_clear, i_gradient_start,
        output o_b1_full, o_gradient_data, o_gradient_data_ready, o_busy
    );
endinterface

`default_nettype wire

// File: rtl/sobel_gradient.sv
// ============================================================================
//  Module      : sobel_gradient
//  Description : 3x3 Sobel gradient on a nine-pixel window. Pixels are loaded
//                one at a time; a start pulse walks the window in nine cycles,
//                accumulating GX/GY, then registers the saturated magnitude
//                |GX|+|GY| (or a binarised value) with a one-cycle ready pulse.
//  Parameters  : THRESH  binarisation threshold (only with SOBEL_THRESHOLD_EN)
//  Macros      : SOBEL_THRESHOLD_EN  output 8'hFF/8'h00 by comparing the
//                                    saturated magnitude against THRESH
//  Ports       : clk    clock, rising edge
//                n_rst  asynchronous active-low reset
//                bus    sobel_gradient_if.slave (pixel/command/result signals)
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module sobel_gradient #(
    parameter int THRESH = 128
) (
    input  wire logic         clk,
    input  wire logic         n_rst,
    sobel_gradient_if.slave   bus
);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_COMPUTE = 2'd1;
    localparam logic [1:0] c_ST_DONE    = 2'd2;
    localparam logic [3:0] c_WIN_SIZE   = 4'd9;
    localparam logic [3:0] c_LAST_IDX   = 4'd8;

    // A threshold outside 0..256 cannot be represented against an 8-bit value.
    if (THRESH < 0 || THRESH > 256) begin : g_thresh_range
        $error("sobel_gradient: THRESH must be within 0..256");
    end

    logic [1:0]         r_state;
    logic [3:0]         r_count;
    logic [3:0]         r_idx;
    logic signed [10:0] r_gx;
    logic signed [10:0] r_gy;
    logic [7:0]         r_win [0:8];
    logic [7:0]         r_data;
    logic               r_ready;

    logic signed [10:0] w_pix;
    logic signed [10:0] w_pix2;
    logic signed [10:0] w_term_x;
    logic signed [10:0] w_term_y;
    logic [10:0]        w_abs_x;
    logic [10:0]        w_abs_y;
    logic [11:0]        w_mag;
    logic [7:0]         w_sat;
    logic [7:0]         w_result;

    // Kernel taps for the current window position; x2 weights are a shift.
    always_comb begin
        w_pix    = {3'b000, r_win[r_idx]};
        w_pix2   = {2'b00, r_win[r_idx], 1'b0};
        w_term_x = '0;
        w_term_y = '0;
        case (r_idx)
            4'd0: begin w_term_x = -w_pix;  w_term_y = -w_pix;  end
            4'd1: begin                     w_term_y = -w_pix2; end
            4'd2: begin w_term_x =  w_pix;  w_term_y = -w_pix;  end
            4'd3: begin w_term_x = -w_pix2;                     end
            4'd5: begin w_term_x =  w_pix2;                     end
            4'd6: begin w_term_x = -w_pix;  w_term_y =  w_pix;  end
            4'd7: begin                     w_term_y =  w_pix2; end
            4'd8: begin w_term_x =  w_pix;  w_term_y =  w_pix;  end
            default: begin end
        endcase
    end

    // |GX| <= 1020 so the negated value always fits in 11 bits.
    assign w_abs_x = r_gx[10] ? 11'(-r_gx) : 11'(r_gx);
    assign w_abs_y = r_gy[10] ? 11'(-r_gy) : 11'(r_gy);
    assign w_mag   = {1'b0, w_abs_x} + {1'b0, w_abs_y};
    assign w_sat   = (w_mag > 12'd255) ? 8'hFF : w_mag[7:0];

`ifdef SOBEL_THRESHOLD_EN
    localparam logic [8:0] c_THRESH = 9'(THRESH);
    assign w_result = ({1'b0, w_sat} >= c_THRESH) ? 8'hFF : 8'h00;
`else
    assign w_result = w_sat;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= c_ST_IDLE;
            r_count <= '0;
            r_idx   <= '0;
            r_gx    <= '0;
            r_gy    <= '0;
            r_data  <= '0;
            r_ready <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                r_win[i] <= '0;
            end
        end else begin
            r_ready <= 1'b0;

            // Clear beats a simultaneous save; window contents are kept.
            if (bus.i_b1_clear) begin
                r_count <= '0;
            end else if (bus.i_b1_save && (r_state == c_ST_IDLE) &&
                         (r_count < c_WIN_SIZE)) begin
                r_win[r_count] <= bus.i_gray_data;
                r_count        <= r_count + 4'd1;
            end

            case (r_state)
                c_ST_IDLE: begin
                    if (bus.i_gradient_start && (r_count == c_WIN_SIZE)) begin
                        r_state <= c_ST_COMPUTE;
                        r_idx   <= '0;
                        r_gx    <= '0;
                        r_gy    <= '0;
                    end
                end
                c_ST_COMPUTE: begin
                    r_gx  <= r_gx + w_term_x;
                    r_gy  <= r_gy + w_term_y;
                    r_idx <= r_idx + 4'd1;
                    if (r_idx == c_LAST_IDX) begin
                        r_state <= c_ST_DONE;
                    end
                end
                c_ST_DONE: begin
                    r_data  <= w_result;
                    r_ready <= 1'b1;
                    r_state <= c_ST_IDLE;
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign bus.o_b1_full             = (r_count == c_WIN_SIZE);
    assign bus.o_gradient_data       = r_data;
    assign bus.o_gradient_data_ready = r_ready;
    assign bus.o_busy                = (r_state == c_ST_COMPUTE) ||
                                       (r_state == c_ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_sobel_gradient.sv
// ============================================================================
//  Module      : tb_sobel_gradient
//  Description : Self-checking bench for sobel_gradient. Random and directed
//                windows are compared against a convolution reference model.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sobel_gradient;

    logic clk = 1'b0;
    logic n_rst;

    sobel_gradient_if bus ();

    sobel_gradient #(.THRESH(128)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int m_win [9];
    int m_count = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Plain 3x3 convolution with the Sobel kernels.
    function automatic int ref_result(input int w [9]);
        int kx [9] = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
        int ky [9] = '{-1, -2, -1, 0, 0, 0, 1, 2, 1};
        int gx = 0;
        int gy = 0;
        int m;
        for (int i = 0; i < 9; i++) begin
            gx += kx[i] * w[i];
            gy += ky[i] * w[i];
        end
        m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        if (m > 255) m = 255;
`ifdef SOBEL_THRESHOLD_EN
        return (m >= 128) ? 255 : 0;
`else
        return m;
`endif
    endfunction

    task automatic save(input int px);
        @(negedge clk);
        bus.i_b1_save   = 1'b1;
        bus.i_gray_data = 8'(px);
        if (m_count < 9) begin
            m_win[m_count] = px;
            m_count++;
        end
        @(negedge clk);
        bus.i_b1_save = 1'b0;
    endtask

    task automatic clear_pulse();
        @(negedge clk);
        bus.i_b1_clear = 1'b1;
        m_count = 0;
        @(negedge clk);
        bus.i_b1_clear = 1'b0;
    endtask

    task automatic fill(input int px [9]);
        clear_pulse();
        for (int i = 0; i < 9; i++) save(px[i]);
    endtask

    // Start a computation; optionally pulse clear / save at a given cycle
    // offset (counted in edges after the start edge) while it is running.
    task automatic run_grad(input string tag, input int clr_at, input int sav_at);
        int exp;
        int edges;
        exp = ref_result(m_win);
        @(negedge clk);
        bus.i_gradient_start = 1'b1;
        @(negedge clk);
        bus.i_gradient_start = 1'b0;
        chk({tag, "_busy"}, int'(bus.o_busy), 1);
        edges = 0;
        while (bus.o_gradient_data_ready !== 1'b1 && edges < 30) begin
            bus.i_b1_clear  = (edges == clr_at);
            bus.i_b1_save   = (edges == sav_at);
            bus.i_gray_data = 8'd123;
            @(negedge clk);
            edges++;
        end
        bus.i_b1_clear = 1'b0;
        bus.i_b1_save  = 1'b0;
        if (clr_at >= 0) m_count = 0;
        chk({tag, "_latency"}, edges, 10);
        chk({tag, "_data"}, int'(bus.o_gradient_data), exp);
        @(negedge clk);
        chk({tag, "_ready_pulse"}, int'(bus.o_gradient_data_ready), 0);
        chk({tag, "_idle"}, int'(bus.o_busy), 0);
        chk({tag, "_hold"}, int'(bus.o_gradient_data), exp);
    endtask

    initial begin
        int w [9];
        int seen_busy;
        int seen_ready;

        bus.i_gray_data      = '0;
        bus.i_b1_save        = 1'b0;
        bus.i_b1_clear       = 1'b0;
        bus.i_gradient_start = 1'b0;
        n_rst = 1'b0;
        #12;
        chk("rst_full",  int'(bus.o_b1_full), 0);
        chk("rst_busy",  int'(bus.o_busy), 0);
        chk("rst_data",  int'(bus.o_gradient_data), 0);
        chk("rst_ready", int'(bus.o_gradient_data_ready), 0);
        @(negedge clk);
        n_rst = 1'b1;

        // Flat window: zero gradient.
        clear_pulse();
        for (int i = 0; i < 8; i++) save(100);
        chk("flat_full8", int'(bus.o_b1_full), 0);
        save(100);
        chk("flat_full9", int'(bus.o_b1_full), 1);
        run_grad("flat", -1, -1);

        // Vertical edge at full contrast: saturates.
        w = '{0, 0, 255, 0, 0, 255, 0, 0, 255};
        fill(w);
        run_grad("edge255", -1, -1);

        // Weak vertical edge: 40, or 0 when binarised.
        w = '{0, 0, 10, 0, 0, 10, 0, 0, 10};
        fill(w);
        run_grad("edge10", -1, -1);

        // Random windows, biased toward the extremes.
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < 9; i++) begin
                case ($urandom_range(0, 3))
                    0:       w[i] = 0;
                    1:       w[i] = 255;
                    default: w[i] = int'($urandom_range(0, 255));
                endcase
            end
            fill(w);
            run_grad($sformatf("rand%0d", t), -1, -1);
        end

        // Tenth save is ignored.
        for (int i = 0; i < 9; i++) w[i] = int'($urandom_range(0, 255));
        fill(w);
        save(77);
        chk("ten_full", int'(bus.o_b1_full), 1);
        run_grad("ten", -1, -1);

        // Save and clear together: clear wins.
        @(negedge clk);
        bus.i_b1_save  = 1'b1;
        bus.i_b1_clear = 1'b1;
        bus.i_gray_data = 8'd50;
        m_count = 0;
        @(negedge clk);
        bus.i_b1_save  = 1'b0;
        bus.i_b1_clear = 1'b0;
        chk("saveclr_full", int'(bus.o_b1_full), 0);
        for (int i = 0; i < 8; i++) save(int'($urandom_range(0, 255)));
        chk("saveclr_full8", int'(bus.o_b1_full), 0);
        save(200);
        chk("saveclr_full9", int'(bus.o_b1_full), 1);
        run_grad("saveclr", -1, -1);

        // Clear and save during computation: result unaffected, save ignored.
        for (int i = 0; i < 9; i++) w[i] = int'($urandom_range(0, 255));
        fill(w);
        run_grad("busyclr", 2, 4);
        chk("busyclr_full", int'(bus.o_b1_full), 0);
        for (int i = 0; i < 9; i++) w[i] = int'($urandom_range(0, 255));
        for (int i = 0; i < 9; i++) save(w[i]);
        chk("busyclr_refill", int'(bus.o_b1_full), 1);
        run_grad("busyclr2", -1, -1);

        // Start with only 8 pixels: ignored.
        clear_pulse();
        for (int i = 0; i < 8; i++) save(30 * i);
        @(negedge clk);
        bus.i_gradient_start = 1'b1;
        @(negedge clk);
        bus.i_gradient_start = 1'b0;
        seen_busy = 0;
        seen_ready = 0;
        for (int c = 0; c < 12; c++) begin
            if (bus.o_busy === 1'b1) seen_busy = 1;
            if (bus.o_gradient_data_ready === 1'b1) seen_ready = 1;
            @(negedge clk);
        end
        chk("short_busy",  seen_busy, 0);
        chk("short_ready", seen_ready, 0);

        // Reset in the middle of a computation.
        w = '{0, 0, 255, 0, 0, 255, 0, 0, 255};
        fill(w);
        run_grad("prerst", -1, -1);
        fill(w);
        @(negedge clk);
        bus.i_gradient_start = 1'b1;
        @(negedge clk);
        bus.i_gradient_start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_rst = 1'b0;
        #1;
        chk("midrst_busy",  int'(bus.o_busy), 0);
        chk("midrst_full",  int'(bus.o_b1_full), 0);
        chk("midrst_data",  int'(bus.o_gradient_data), 0);
        chk("midrst_ready", int'(bus.o_gradient_data_ready), 0);
        m_count = 0;
        for (int i = 0; i < 9; i++) m_win[i] = 0;
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        seen_ready = 0;
        seen_busy = 0;
        for (int c = 0; c < 15; c++) begin
            if (bus.o_gradient_data_ready === 1'b1) seen_ready = 1;
            if (bus.o_busy === 1'b1) seen_busy = 1;
            @(negedge clk);
        end
        chk("midrst_noready", seen_ready, 0);
        chk("midrst_nobusy",  seen_busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
